// File: rtl/lsu_pkg.sv
// ============================================================================
// Package  : lsu_pkg
// Purpose  : Shared codes and helpers for the lane-2 memory stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // FSM state codes
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_REQ  = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;
  localparam logic [1:0] STATE_DROP = 2'd3;

  // Access size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // WB2 result select codes
  localparam logic [1:0] RSEL_ALU  = 2'd0;
  localparam logic [1:0] RSEL_PC4  = 2'd1;
  localparam logic [1:0] RSEL_MEMC = 2'd2;
  localparam logic [1:0] RSEL_ZERO = 2'd3;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align_t.sv
// ============================================================================
// Module   : lsu_load_align_t
// Purpose  : Selects the addressed lane of a read word and sign/zero extends it.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_align_t
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = rdata[{offset, 3'b000} +: 8];
  assign lane16 = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = rdata;
    case (size)
      SIZE_BYTE: ext_data = {{(XLEN-8){lane8[7] & ~uns}}, lane8};
      SIZE_HALF: ext_data = {{(XLEN-16){lane16[15] & ~uns}}, lane16};
      default:   ext_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem2_lsu_stage_t.sv
// ============================================================================
// Module   : mem2_lsu_stage_t
// Purpose  : Lane-2 memory stage: runs one load/store on the data bus and
//            registers the WB2 pipeline set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem2_lsu_stage_t
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RSEL_MEM = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_rfwt_sel,
  input  logic            in_wten,
  input  logic            in_ld,
  input  logic            in_st,
  input  logic [1:0]      in_size,
  input  logic            in_uns,
  input  logic [XLEN-1:0] in_stdata,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb2_valid,
  output logic [XLEN-1:0] wb2_pc,
  output logic [XLEN-1:0] wb2_alu,
  output logic [XLEN-1:0] wb2_memdat,
  output logic [4:0]      wb2_rd,
  output logic [1:0]      wb2_rfwt_sel,
  output logic            wb2_wten,
  output logic            misalign
);

  logic [1:0]      state;
  logic [1:0]      next_state;

  // Latched memory operation
  logic [XLEN-1:0] op_pc;
  logic [XLEN-1:0] op_addr;
  logic [4:0]      op_rd;
  logic [1:0]      op_sel;
  logic            op_wten;
  logic            op_ld;
  logic [1:0]      op_size;
  logic            op_uns;
  logic [3:0]      op_be;
  logic [XLEN-1:0] op_wdata;

  logic            accept;
  logic            is_mem;
  logic            acc_mis;
  logic            latch_op;
  logic            ret;
  logic            ret_direct;
  logic            ret_mis;
  logic [XLEN-1:0] ret_memdat;
  logic [XLEN-1:0] load_value;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic            unused_sel_is_mem;

  assign in_ready   = (state == STATE_IDLE);
  assign accept     = in_valid && in_ready && !flush;
  assign is_mem     = in_ld || in_st;
  assign acc_mis    = is_mem && is_misaligned(in_size, in_alu[1:0]);

  assign dmem_req   = (state == STATE_REQ);
  assign dmem_we    = dmem_req && !op_ld;
  assign dmem_addr  = {op_addr[XLEN-1:2], 2'b00};
  assign dmem_be    = op_be;
  assign dmem_wdata = op_wdata;

  // WB2 treats memdat as the result only under this select code
  assign unused_sel_is_mem = (in_rfwt_sel == RSEL_MEM[1:0]);

  lsu_load_align_t #(
    .XLEN(XLEN)
  ) u_align (
    .rdata    (dmem_rdata),
    .offset   (op_addr[1:0]),
    .size     (op_size),
    .uns      (op_uns),
    .ext_data (load_value)
  );

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_stdata;
    case (in_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << in_alu[1:0];
        st_wdata = {(XLEN/8){in_stdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = 4'b0011 << {in_alu[1], 1'b0};
        st_wdata = {(XLEN/16){in_stdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_stdata;
      end
    endcase
  end

  // A flush always wins retirement, even when the bus commits the access
  always_comb begin
    next_state = state;
    latch_op   = 1'b0;
    ret        = 1'b0;
    ret_direct = 1'b0;
    ret_mis    = 1'b0;
    ret_memdat = '0;
    case (state)
      STATE_IDLE: begin
        if (accept) begin
          if (!is_mem || acc_mis) begin
            ret        = 1'b1;
            ret_direct = 1'b1;
            ret_mis    = acc_mis;
          end else begin
            latch_op   = 1'b1;
            next_state = STATE_REQ;
          end
        end
      end
      STATE_REQ: begin
        if (dmem_gnt) begin
          if (op_ld) begin
            next_state = flush ? STATE_DROP : STATE_RESP;
          end else begin
            next_state = STATE_IDLE;
            ret        = !flush;
          end
        end else if (flush) begin
          next_state = STATE_IDLE;
        end
      end
      STATE_RESP: begin
        // rvalid together with flush discards the data; DROP would wait forever
        if (dmem_rvalid) begin
          next_state = STATE_IDLE;
          ret        = !flush;
          ret_memdat = load_value;
        end else if (flush) begin
          next_state = STATE_DROP;
        end
      end
      default: begin
        if (dmem_rvalid) begin
          next_state = STATE_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STATE_IDLE;
      op_pc        <= '0;
      op_addr      <= '0;
      op_rd        <= '0;
      op_sel       <= '0;
      op_wten      <= 1'b0;
      op_ld        <= 1'b0;
      op_size      <= '0;
      op_uns       <= 1'b0;
      op_be        <= '0;
      op_wdata     <= '0;
      wb2_valid    <= 1'b0;
      wb2_pc       <= '0;
      wb2_alu      <= '0;
      wb2_memdat   <= '0;
      wb2_rd       <= '0;
      wb2_rfwt_sel <= '0;
      wb2_wten     <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      state     <= next_state;
      wb2_valid <= 1'b0;
      wb2_wten  <= 1'b0;
      misalign  <= 1'b0;
      if (latch_op) begin
        op_pc    <= in_pc;
        op_addr  <= in_alu;
        op_rd    <= in_rd;
        op_sel   <= in_rfwt_sel;
        op_wten  <= in_wten;
        op_ld    <= in_ld;
        op_size  <= in_size;
        op_uns   <= in_uns;
        op_be    <= st_be;
        op_wdata <= st_wdata;
      end
      if (ret) begin
        wb2_valid  <= 1'b1;
        wb2_memdat <= ret_memdat;
        misalign   <= ret_mis;
        if (ret_direct) begin
          wb2_pc       <= in_pc;
          wb2_alu      <= in_alu;
          wb2_rd       <= in_rd;
          wb2_rfwt_sel <= in_rfwt_sel;
          wb2_wten     <= in_wten && !ret_mis;
        end else begin
          wb2_pc       <= op_pc;
          wb2_alu      <= op_addr;
          wb2_rd       <= op_rd;
          wb2_rfwt_sel <= op_sel;
          wb2_wten     <= op_wten;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem2_lsu_stage_t.sv
// ============================================================================
// Module   : tb_mem2_lsu_stage_t
// Purpose  : Randomized scoreboard bench for the lane-2 memory stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem2_lsu_stage_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wten, in_ld, in_st, in_uns, flush;
  logic [31:0] in_pc, in_alu, in_stdata;
  logic [4:0]  in_rd;
  logic [1:0]  in_rfwt_sel, in_size;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb2_valid, wb2_wten, misalign;
  logic [31:0] wb2_pc, wb2_alu, wb2_memdat;
  logic [4:0]  wb2_rd;
  logic [1:0]  wb2_rfwt_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] memdat;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        wten;
    logic        mis;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem2_lsu_stage_t #(.XLEN(32), .RSEL_MEM(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu(in_alu),
    .in_rd(in_rd), .in_rfwt_sel(in_rfwt_sel), .in_wten(in_wten),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_uns(in_uns),
    .in_stdata(in_stdata), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb2_valid(wb2_valid), .wb2_pc(wb2_pc), .wb2_alu(wb2_alu),
    .wb2_memdat(wb2_memdat), .wb2_rd(wb2_rd), .wb2_rfwt_sel(wb2_rfwt_sel),
    .wb2_wten(wb2_wten), .misalign(misalign)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference rules expressed with plain arithmetic
  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; flush = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the stage retires
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb2_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("wb2_pc", wb2_pc, e.pc);
          chk("wb2_alu", wb2_alu, e.alu);
          chk("wb2_memdat", wb2_memdat, e.memdat);
          chk("wb2_rd", 32'(wb2_rd), 32'(e.rd));
          chk("wb2_sel", 32'(wb2_rfwt_sel), 32'(e.sel));
          chk("wb2_wten", 32'(wb2_wten), 32'(e.wten));
          chk("misalign", 32'(misalign), 32'(e.mis));
        end
      end else begin
        chk("wten_when_idle", 32'(wb2_wten), 32'd0);
        chk("mis_when_idle", 32'(misalign), 32'd0);
      end
    end
  end

  // kind: 0=alu 1=load 2=store. plan: 0 none, 1 flush in REQ before gnt,
  // 2 flush with gnt, 3 flush in RESP, 4 flush at issue
  task automatic run_txn(input int kind, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [1:0] sel, input logic [1:0] sz,
                         input logic wten, input logic uns,
                         input int gdly, input int rdly, input int plan);
    int n;
    logic mis;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    mis = (kind != 0) && model_mis(sz, alu);
    e.pc = pc; e.alu = alu; e.rd = rd; e.sel = sel; e.mis = mis;
    e.wten = mis ? 1'b0 : wten;
    e.memdat = (kind == 1 && !mis) ? model_load(rdata, alu, sz, uns) : 32'd0;
    if (plan == 0 || (plan != 4 && (kind == 0 || mis))) q.push_back(e);

    in_valid = 1'b1; in_pc = pc; in_alu = alu; in_rd = rd; in_rfwt_sel = sel;
    in_wten = wten; in_ld = (kind == 1); in_st = (kind == 2); in_size = sz;
    in_uns = uns; in_stdata = sd; flush = (plan == 4);
    tick();
    clr_in();
    if (plan == 4 || kind == 0 || mis) begin
      chk("no_req", 32'(dmem_req), 32'd0);
      return;
    end

    for (int i = 0; i <= gdly; i++) begin
      chk("req", 32'(dmem_req), 32'd1);
      chk("addr", dmem_addr, alu & 32'hFFFF_FFFC);
      chk("we", 32'(dmem_we), 32'(kind == 2));
      chk("ready_in_req", 32'(in_ready), 32'd0);
      if (kind == 2) begin
        chk("be", 32'(dmem_be), 32'(model_be(sz, alu)));
        chk("wdata", dmem_wdata, model_wdata(sz, sd));
      end
      if (plan == 1) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_drops_req", 32'(dmem_req), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        return;
      end
      if (i == gdly) begin
        dmem_gnt = 1'b1;
        flush = (plan == 2);
      end
      tick();
    end
    dmem_gnt = 1'b0;
    flush = 1'b0;
    chk("req_after_gnt", 32'(dmem_req), 32'd0);
    if (kind == 2) begin
      chk("ready_after_st", 32'(in_ready), 32'd1);
      return;
    end

    for (int i = 0; i <= rdly; i++) begin
      chk("ready_wait_resp", 32'(in_ready), 32'd0);
      if (plan == 3 && i == 0) flush = 1'b1;
      if (i == rdly) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
      end
      tick();
      flush = 1'b0;
    end
    dmem_rvalid = 1'b0;
    dmem_rdata = $urandom;
    chk("ready_after_ld", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, plan, gdly, rdly;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1;
    clr_in();
    in_pc = '0; in_alu = '0; in_rd = '0; in_rfwt_sel = '0; in_wten = 1'b0;
    in_size = '0; in_uns = 1'b0; in_stdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb2_valid", 32'(wb2_valid), 32'd0);
    chk("rst_wb2_pc", wb2_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Directed scenarios
    run_txn(0, 32'h100, 32'h55, 32'h0, 32'h0, 5'd3, 2'd0, 2'd0, 1'b1, 1'b0, 0, 0, 0);
    run_txn(1, 32'h104, 32'h203, 32'h0, 32'h8011_2233, 5'd4, 2'd2, 2'd0, 1'b1, 1'b0, 2, 0, 0);
    run_txn(2, 32'h108, 32'h402, 32'h0000_BEEF, 32'h0, 5'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1, 0, 0);
    run_txn(1, 32'h10C, 32'h301, 32'h0, 32'h0, 5'd7, 2'd2, 2'd2, 1'b1, 1'b0, 0, 0, 0);
    run_txn(1, 32'h110, 32'h300, 32'h0, 32'h1234_5678, 5'd8, 2'd2, 2'd2, 1'b1, 1'b0, 0, 3, 3);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom % 3);
      sz   = 2'($urandom % 3);
      a    = $urandom;
      if ($urandom % 3 != 0) a = a & ~((32'd1 << sz) - 32'd1);
      gdly = int'($urandom % 4);
      rdly = int'($urandom % 4);
      plan = int'($urandom % 8);
      if (plan > 4) plan = 0;
      if (plan == 1 || plan == 2 || plan == 3) plan = ($urandom % 2 == 0) ? plan : 0;
      if (plan == 3 && kind != 1) plan = 0;
      if (plan == 3 && rdly == 0) rdly = 1;
      run_txn(kind, $urandom, a, $urandom, $urandom, 5'($urandom), 2'($urandom),
              sz, 1'($urandom), 1'($urandom), gdly, rdly, plan);
      repeat ($urandom % 2) tick();
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    // Reset while a request is pending
    in_valid = 1'b1; in_pc = 32'h200; in_alu = 32'h500; in_ld = 1'b1; in_st = 1'b0;
    in_size = 2'd2; in_wten = 1'b1; in_rd = 5'd9;
    tick();
    clr_in();
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_idle", 32'(in_ready), 32'd1);
    chk("rst_pc", wb2_pc, 32'd0);
    chk("rst_alu", wb2_alu, 32'd0);
    chk("rst_memdat", wb2_memdat, 32'd0);
    chk("rst_rd", 32'(wb2_rd), 32'd0);
    chk("rst_sel", 32'(wb2_rfwt_sel), 32'd0);
    chk("rst_wten", 32'(wb2_wten), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
